// File: rtl/dffram_ahbl_arbiter_pkg.sv
// Shared types and helpers for the dual-port AHB-Lite front end of a single-port DFFRAM.
package dffram_ahbl_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RDATA = 2'd2
    } port_state_e;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Unsupported sizes decode to no lanes, so the write completes as a no-op.
    function automatic logic [3:0] byte_en_decode(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = '0;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = '1;
            default:    be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dffram_ahbl_arbiter_port.sv
// One AHB-Lite slave port: address-phase capture, per-port FSM and wait-state generation
// against a shared RAM granted by the parent arbiter.
module dffram_ahbl_arbiter_port
    import dffram_ahbl_arbiter_pkg::*;
#(
    parameter int unsigned AW = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          hsel_i,
    input  logic [AW+1:0] haddr_i,
    input  logic          htrans_act_i,
    input  logic          hwrite_i,
    input  logic [2:0]    hsize_i,
    input  logic          hready_i,
    input  logic          gnt_i,
    input  logic [31:0]   ram_do_i,
    output logic          req_o,
    output logic          wr_o,
    output logic [AW-1:0] addr_o,
    output logic [3:0]    be_o,
    output logic          hreadyout_o,
    output logic [31:0]   hrdata_o
);

    port_state_e   state_q, state_d;
    logic          slot_wr_q, slot_wr_d;
    logic [AW-1:0] slot_a_q, slot_a_d;
    logic [3:0]    slot_be_q, slot_be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            slot_wr_q <= 1'b0;
            slot_a_q  <= '0;
            slot_be_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            slot_wr_q <= slot_wr_d;
            slot_a_q  <= slot_a_d;
            slot_be_q <= slot_be_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        hreadyout_o = 1'b1;
        if (state_q == ST_WAIT) begin
            hreadyout_o = gnt_i & slot_wr_q;
        end
        // Gating with our own ready keeps a stalled slot intact even if HREADY is driven loosely.
        accept = hsel_i & htrans_act_i & hready_i & hreadyout_o;

        state_d   = state_q;
        slot_wr_d = slot_wr_q;
        slot_a_d  = slot_a_q;
        slot_be_d = slot_be_q;
        rdata_d   = rdata_q;

        if (accept) begin
            slot_wr_d = hwrite_i;
            slot_a_d  = haddr_i[AW+1:2];
            slot_be_d = byte_en_decode(hsize_i, haddr_i[1:0]);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gnt_i) begin
                    if (slot_wr_q) state_d = accept ? ST_WAIT : ST_IDLE;
                    else           state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                rdata_d = ram_do_i;
                state_d = accept ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_o    = (state_q == ST_WAIT);
    assign wr_o     = slot_wr_q;
    assign addr_o   = slot_a_q;
    assign be_o     = slot_be_q;
    assign hrdata_o = (state_q == ST_RDATA) ? ram_do_i : rdata_q;

endmodule

// File: rtl/dffram_ahbl_arbiter.sv
// Two AHB-Lite slave ports sharing one single-port DFFRAM: round-robin or fixed-priority
// arbitration with the granted port's address/strobes/data steered onto the macro.
module dffram_ahbl_arbiter
    import dffram_ahbl_arbiter_pkg::*;
#(
    parameter int unsigned AW        = 9,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          P0_HSEL,
    input  logic [31:0]   P0_HADDR,
    input  logic [1:0]    P0_HTRANS,
    input  logic          P0_HWRITE,
    input  logic [2:0]    P0_HSIZE,
    input  logic          P0_HREADY,
    input  logic [31:0]   P0_HWDATA,
    output logic          P0_HREADYOUT,
    output logic [31:0]   P0_HRDATA,
    input  logic          P1_HSEL,
    input  logic [31:0]   P1_HADDR,
    input  logic [1:0]    P1_HTRANS,
    input  logic          P1_HWRITE,
    input  logic [2:0]    P1_HSIZE,
    input  logic          P1_HREADY,
    input  logic [31:0]   P1_HWDATA,
    output logic          P1_HREADYOUT,
    output logic [31:0]   P1_HRDATA,
    output logic          ram_en,
    output logic [AW-1:0] ram_a,
    output logic [31:0]   ram_di,
    output logic [3:0]    ram_we,
    input  logic [31:0]   ram_do
);

    logic          req0, req1, gnt0, gnt1;
    logic          wr0, wr1;
    logic [AW-1:0] a0, a1;
    logic [3:0]    be0, be1;
    logic          last1_q, last1_d;
    logic [AW-1:0] ram_a_q;
    logic [31:0]   ram_di_q;
    logic          unused_ahb;

    assign unused_ahb = ^{P0_HADDR[31:AW+2], P1_HADDR[31:AW+2], P0_HTRANS[0], P1_HTRANS[0]};

    dffram_ahbl_arbiter_port #(.AW(AW)) u_port0 (
        .clk_i        (HCLK),
        .rst_ni       (HRESETn),
        .hsel_i       (P0_HSEL),
        .haddr_i      (P0_HADDR[AW+1:0]),
        .htrans_act_i (P0_HTRANS[1]),
        .hwrite_i     (P0_HWRITE),
        .hsize_i      (P0_HSIZE),
        .hready_i     (P0_HREADY),
        .gnt_i        (gnt0),
        .ram_do_i     (ram_do),
        .req_o        (req0),
        .wr_o         (wr0),
        .addr_o       (a0),
        .be_o         (be0),
        .hreadyout_o  (P0_HREADYOUT),
        .hrdata_o     (P0_HRDATA)
    );

    dffram_ahbl_arbiter_port #(.AW(AW)) u_port1 (
        .clk_i        (HCLK),
        .rst_ni       (HRESETn),
        .hsel_i       (P1_HSEL),
        .haddr_i      (P1_HADDR[AW+1:0]),
        .htrans_act_i (P1_HTRANS[1]),
        .hwrite_i     (P1_HWRITE),
        .hsize_i      (P1_HSIZE),
        .hready_i     (P1_HREADY),
        .gnt_i        (gnt1),
        .ram_do_i     (ram_do),
        .req_o        (req1),
        .wr_o         (wr1),
        .addr_o       (a1),
        .be_o         (be1),
        .hreadyout_o  (P1_HREADYOUT),
        .hrdata_o     (P1_HRDATA)
    );

    // last1_q records which port won most recently; reset to 1 so P0 wins the first tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if ((FIXED_PRI != 0) || last1_q) gnt0 = 1'b1;
            else                             gnt1 = 1'b1;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
        last1_d = last1_q;
        if (gnt0 || gnt1) last1_d = gnt1;
    end

    always_comb begin
        ram_en = gnt0 | gnt1;
        ram_a  = ram_a_q;
        ram_di = ram_di_q;
        ram_we = '0;
        if (gnt0) begin
            ram_a  = a0;
            ram_di = P0_HWDATA;
            ram_we = wr0 ? be0 : 4'b0000;
        end else if (gnt1) begin
            ram_a  = a1;
            ram_di = P1_HWDATA;
            ram_we = wr1 ? be1 : 4'b0000;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last1_q  <= 1'b1;
            ram_a_q  <= '0;
            ram_di_q <= '0;
        end else begin
            last1_q  <= last1_d;
            ram_a_q  <= ram_a;
            ram_di_q <= ram_di;
        end
    end

endmodule

// File: tb/tb_dffram_ahbl_arbiter.sv
// Bench for dffram_ahbl_arbiter: a round-robin and a fixed-priority instance, each with its own RAM model.
module tb_dffram_ahbl_arbiter;

    localparam int unsigned AW = 9;
    localparam logic [2:0] SZ_B = 3'b000;
    localparam logic [2:0] SZ_H = 3'b001;
    localparam logic [2:0] SZ_W = 3'b010;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        hsel   [2][2];
    logic [31:0] haddr  [2][2];
    logic [1:0]  htrans [2][2];
    logic        hwrite [2][2];
    logic [2:0]  hsize  [2][2];
    logic [31:0] hwdata [2][2];
    logic        hrdyo  [2][2];
    logic [31:0] hrdata [2][2];
    logic          ram_en [2];
    logic [AW-1:0] ram_a  [2];
    logic [31:0]   ram_di [2];
    logic [3:0]    ram_we [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] sbq0[$];
    logic [31:0] sbq1[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [512];
        logic [31:0] do_q;

        dffram_ahbl_arbiter #(.AW(AW), .FIXED_PRI(g)) u_dut (
            .HCLK(clk), .HRESETn(rst_n),
            .P0_HSEL(hsel[g][0]), .P0_HADDR(haddr[g][0]), .P0_HTRANS(htrans[g][0]),
            .P0_HWRITE(hwrite[g][0]), .P0_HSIZE(hsize[g][0]), .P0_HREADY(hrdyo[g][0]),
            .P0_HWDATA(hwdata[g][0]), .P0_HREADYOUT(hrdyo[g][0]), .P0_HRDATA(hrdata[g][0]),
            .P1_HSEL(hsel[g][1]), .P1_HADDR(haddr[g][1]), .P1_HTRANS(htrans[g][1]),
            .P1_HWRITE(hwrite[g][1]), .P1_HSIZE(hsize[g][1]), .P1_HREADY(hrdyo[g][1]),
            .P1_HWDATA(hwdata[g][1]), .P1_HREADYOUT(hrdyo[g][1]), .P1_HRDATA(hrdata[g][1]),
            .ram_en(ram_en[g]), .ram_a(ram_a[g]), .ram_di(ram_di[g]), .ram_we(ram_we[g]),
            .ram_do(do_q)
        );

        always @(posedge clk) begin
            if (ram_en[g]) begin
                if (ram_we[g] == 4'b0000) do_q <= mem[ram_a[g]];
                for (int b = 0; b < 4; b++)
                    if (ram_we[g][b]) mem[ram_a[g]][8*b +: 8] <= ram_di[g][8*b +: 8];
            end
        end
    end

    typedef struct {
        int          p;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          exp_waits;
        logic [3:0]  exp_we;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle(input int g, input int p);
        hsel[g][p]   = 1'b0;
        htrans[g][p] = 2'b00;
        haddr[g][p]  = '0;
        hwrite[g][p] = 1'b0;
        hsize[g][p]  = SZ_W;
        hwdata[g][p] = '0;
    endtask

    task automatic xfer(input string name, input int g, input int p, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                        input int exp_waits, input logic [31:0] exp_rd, output logic [3:0] we_seen);
        int n;
        int waits;
        logic [31:0] exp;
        @(negedge clk);
        hsel[g][p]   = 1'b1;
        htrans[g][p] = 2'b10;
        haddr[g][p]  = addr;
        hwrite[g][p] = wr;
        hsize[g][p]  = size;
        if (!wr) begin
            if (p == 0) sbq0.push_back(exp_rd);
            else        sbq1.push_back(exp_rd);
        end
        n = 0;
        #1;
        while (!hrdyo[g][p] && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        @(negedge clk);
        hsel[g][p]   = 1'b0;
        htrans[g][p] = 2'b00;
        hwdata[g][p] = wdata;
        waits = 0;
        #1;
        while (!hrdyo[g][p] && waits < 50) begin @(negedge clk); #1; waits++; end
        if (n >= 50) waits = 999;
        chk({name, " waits"}, 32'(waits), 32'(exp_waits));
        we_seen = ram_we[g];
        if (!wr) begin
            if (p == 0) exp = sbq0.pop_front();
            else        exp = sbq1.pop_front();
            chk({name, " rdata"}, hrdata[g][p], exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) for (int p = 0; p < 2; p++) bus_idle(g, p);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] we0, we1;
        vecs[0]  = '{0, 1'b1, 32'h10, SZ_W, 32'hDEADBEEF, 0, 4'hF, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'h10, SZ_W, 32'h0,        1, 4'h0, 32'hDEADBEEF};
        vecs[2]  = '{1, 1'b1, 32'h20, SZ_B, 32'h00000011, 0, 4'h1, 32'h0};
        vecs[3]  = '{1, 1'b1, 32'h21, SZ_B, 32'h00002200, 0, 4'h2, 32'h0};
        vecs[4]  = '{1, 1'b1, 32'h22, SZ_B, 32'h00330000, 0, 4'h4, 32'h0};
        vecs[5]  = '{1, 1'b1, 32'h23, SZ_B, 32'h44000000, 0, 4'h8, 32'h0};
        vecs[6]  = '{1, 1'b0, 32'h20, SZ_W, 32'h0,        1, 4'h0, 32'h44332211};
        vecs[7]  = '{1, 1'b1, 32'h22, SZ_H, 32'hAAAA0000, 0, 4'hC, 32'h0};
        vecs[8]  = '{1, 1'b0, 32'h20, SZ_W, 32'h0,        1, 4'h0, 32'hAAAA2211};
        vecs[9]  = '{0, 1'b1, 32'h20, SZ_H, 32'h0000BBBB, 0, 4'h3, 32'h0};
        vecs[10] = '{0, 1'b1, 32'h20, 3'b011, 32'hFFFFFFFF, 0, 4'h0, 32'h0};
        vecs[11] = '{0, 1'b0, 32'h20, SZ_W, 32'h0,        1, 4'h0, 32'hAAAABBBB};
        vecs[12] = '{0, 1'b1, 32'h00, SZ_W, 32'h01010101, 0, 4'hF, 32'h0};
        vecs[13] = '{1, 1'b1, 32'h04, SZ_W, 32'h02020202, 0, 4'hF, 32'h0};
        vecs[14] = '{0, 1'b1, 32'h08, SZ_W, 32'hCAFEF00D, 0, 4'hF, 32'h0};
        vecs[15] = '{1, 1'b0, 32'h10, SZ_W, 32'h0,        1, 4'h0, 32'hDEADBEEF};

        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) for (int p = 0; p < 2; p++) bus_idle(g, p);
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("reset g%0d p%0d hreadyout", g, p), 32'(hrdyo[g][p]), 32'd1);
                chk($sformatf("reset g%0d p%0d hrdata", g, p), hrdata[g][p], 32'd0);
            end
            chk($sformatf("reset g%0d ram_en", g), 32'(ram_en[g]), 32'd0);
            chk($sformatf("reset g%0d ram_we", g), 32'(ram_we[g]), 32'd0);
            chk($sformatf("reset g%0d ram_a", g), 32'(ram_a[g]), 32'd0);
            chk($sformatf("reset g%0d ram_di", g), ram_di[g], 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            xfer($sformatf("vec%0d", i), 0, vecs[i].p, vecs[i].wr, vecs[i].addr, vecs[i].size,
                 vecs[i].wdata, vecs[i].exp_waits, vecs[i].exp_rd, we0);
            chk($sformatf("vec%0d ram_we", i), 32'(we0), 32'(vecs[i].exp_we));
        end

        // read data holds outside RDATA; IDLE/BUSY transfers are ignored
        @(negedge clk);
        hsel[0][0] = 1'b1; htrans[0][0] = 2'b01; haddr[0][0] = 32'h10;
        #1;
        chk("busy hreadyout", 32'(hrdyo[0][0]), 32'd1);
        @(negedge clk);
        #1;
        chk("busy no ram_en", 32'(ram_en[0]), 32'd0);
        chk("hrdata hold", hrdata[0][1], 32'hDEADBEEF);
        bus_idle(0, 0);

        // contention after reset: P0 first, then P1
        do_reset();
        fork
            xfer("contA p0", 0, 0, 1'b0, 32'h0, SZ_W, 32'h0, 1, 32'h01010101, we0);
            xfer("contA p1", 0, 1, 1'b0, 32'h4, SZ_W, 32'h0, 2, 32'h02020202, we1);
        join
        xfer("lone p0", 0, 0, 1'b0, 32'h0, SZ_W, 32'h0, 1, 32'h01010101, we0);
        fork
            xfer("contB p0", 0, 0, 1'b0, 32'h4, SZ_W, 32'h0, 2, 32'h02020202, we0);
            xfer("contB p1", 0, 1, 1'b0, 32'h0, SZ_W, 32'h0, 1, 32'h01010101, we1);
        join

        // P0 write and P1 read of one word; P0 won last, so P1 reads first and sees old data
        fork
            xfer("raw p0w", 0, 0, 1'b1, 32'h8, SZ_W, 32'h5, 1, 32'h0, we0);
            xfer("raw p1r", 0, 1, 1'b0, 32'h8, SZ_W, 32'h0, 1, 32'hCAFEF00D, we1);
        join
        chk("raw p0w ram_we", 32'(we0), 32'hF);
        xfer("raw p1r2", 0, 1, 1'b0, 32'h8, SZ_W, 32'h0, 1, 32'h5, we1);

        // reset while P1 sits in WAIT
        @(negedge clk);
        hsel[0][1] = 1'b1; htrans[0][1] = 2'b10; haddr[0][1] = 32'h10; hwrite[0][1] = 1'b0; hsize[0][1] = SZ_W;
        @(negedge clk);
        bus_idle(0, 1);
        #1;
        chk("pre-rst p1 in wait", 32'(hrdyo[0][1]), 32'd0);
        chk("pre-rst ram_en", 32'(ram_en[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst p1 hreadyout", 32'(hrdyo[0][1]), 32'd1);
        chk("rst ram_en", 32'(ram_en[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release ram_en", 32'(ram_en[0]), 32'd0);
        xfer("post-rst p1", 0, 1, 1'b0, 32'h10, SZ_W, 32'h0, 1, 32'hDEADBEEF, we1);

        // fixed priority: P1 only served while P0 is not requesting
        xfer("fp init w1", 1, 1, 1'b1, 32'h40, SZ_W, 32'h600DCAFE, 0, 32'h0, we1);
        xfer("fp init w0", 1, 0, 1'b1, 32'h00, SZ_W, 32'h12345678, 0, 32'h0, we0);
        xfer("fp init r0", 1, 0, 1'b0, 32'h00, SZ_W, 32'h0, 1, 32'h12345678, we0);
        fork
            begin
                @(negedge clk);
                hsel[1][0] = 1'b1; htrans[1][0] = 2'b10; haddr[1][0] = 32'h0;
                hwrite[1][0] = 1'b0; hsize[1][0] = SZ_W;
                for (int c = 0; c < 20; c++) begin
                    #1;
                    if (ram_en[1] && ram_a[1] == 9'd16)
                        chk("fp p1 grant in p0 gap", 32'(hrdyo[1][0]), 32'd1);
                    @(negedge clk);
                end
                bus_idle(1, 0);
            end
            xfer("fp p1", 1, 1, 1'b0, 32'h40, SZ_W, 32'h0, 2, 32'h600DCAFE, we1);
        join
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
